// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the word serializer and its future deserializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAPW  = 2'd3
  } ser_state_t;

  localparam int W_DEF     = 16;
  localparam int CNT_W     = $clog2(W_DEF);
  localparam int GAP_CNT_W = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable W-bit shift register with selectable shift direction.
// With SER_PARITY_EN defined it also keeps a running XOR of the bits shifted out.
module ser_shift_reg #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
`ifdef SER_PARITY_EN
  output logic         par_o,
`endif
  output logic         bit_o
);

  logic [W-1:0] sr_q, sr_d;

  assign bit_o = MSB_FIRST ? sr_q[W-1] : sr_q[0];

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = MSB_FIRST ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= {W{1'b0}};
    else     sr_q <= sr_d;
  end

`ifdef SER_PARITY_EN
  logic par_q, par_d;

  assign par_o = par_q;

  // After the last shift, par_q equals the XOR of the whole loaded word.
  always_comb begin
    par_d = par_q;
    if (load)       par_d = 1'b0;
    else if (shift) par_d = par_q ^ bit_o;
    else            par_d = par_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

endmodule

// File: rtl/word16_serializer.sv
// Parallel-word to serial-bit transmitter with valid/ready input and SV/FS/DONE framing.
// Optional even-parity bit after each frame: define SER_PARITY_EN.
module word16_serializer
  import ser_pkg::*;
#(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic         CK,
  input  logic         CLR,
  input  logic [W-1:0] D,
  input  logic         DV,
  output logic         RDY,
  output logic         SO,
  output logic         SV,
  output logic         FS,
  output logic         DONE
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [GAP_CNT_W-1:0] GAP_ONE = GAP_CNT_W'(1);
  // The IDLE accept cycle is itself one gap cycle, so GAPW covers GAP-1 of them.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 1) ? GAP - 2 : 0);
  localparam ser_state_t POST_STATE = (GAP > 1) ? GAPW : IDLE;
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit STREAM_SHIFT = (GAP == 0) && !PAR_EN;

  ser_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   so_q, so_d;
  logic                   sv_q, sv_d;
  logic                   fs_q, fs_d;
  logic                   done_q, done_d;
  logic                   rdy_s, accept_s, load_s, shift_s, bit_s;
`ifdef SER_PARITY_EN
  logic                   par_s;
`endif

  ser_shift_reg #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk   (CK),
    .rst   (CLR),
    .load  (load_s),
    .shift (shift_s),
    .d     (D),
`ifdef SER_PARITY_EN
    .par_o (par_s),
`endif
    .bit_o (bit_s)
  );

  always_comb begin
    case (state_q)
      IDLE:    rdy_s = 1'b1;
      SHIFT:   rdy_s = STREAM_SHIFT && (cnt_q == {CW{1'b0}});
      PAR:     rdy_s = (GAP == 0);
      GAPW:    rdy_s = 1'b0;
      default: rdy_s = 1'b0;
    endcase
  end

  // Gated by CLR so nothing is advertised while reset is held.
  assign RDY      = rdy_s & ~CLR;
  assign accept_s = DV & RDY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    so_d    = so_q;
    sv_d    = 1'b0;
    fs_d    = 1'b0;
    done_d  = 1'b0;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_s  = 1'b1;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        so_d    = bit_s;
        sv_d    = 1'b1;
        fs_d    = (cnt_q == CNT_LAST);
        shift_s = 1'b1;
        if (cnt_q == {CW{1'b0}}) begin
          done_d = ~PAR_EN;
          if (PAR_EN) begin
            state_d = PAR;
          end else if (accept_s) begin
            load_s  = 1'b1;
            cnt_d   = CNT_LAST;
            state_d = SHIFT;
          end else begin
            state_d = POST_STATE;
            gap_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PAR: begin
`ifdef SER_PARITY_EN
        so_d   = par_s;
        sv_d   = 1'b1;
        done_d = 1'b1;
        if (accept_s) begin
          load_s  = 1'b1;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end else begin
          state_d = POST_STATE;
          gap_d   = GAP_LOAD;
        end
`else
        state_d = IDLE;
`endif
      end
      GAPW: begin
        if (gap_q == {GAP_CNT_W{1'b0}}) state_d = IDLE;
        else                            gap_d   = gap_q - GAP_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      gap_q   <= {GAP_CNT_W{1'b0}};
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      so_q    <= so_d;
      sv_q    <= sv_d;
      fs_q    <= fs_d;
      done_q  <= done_d;
    end
  end

  assign SO   = so_q;
  assign SV   = sv_q;
  assign FS   = fs_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_word16_serializer.sv
// Directed bench for word16_serializer: three instances cover MSB/LSB order and GAP = 0/3.
// Parity expectations follow SER_PARITY_EN.
module tb_word16_serializer;

  localparam int W = 16;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = W + PB;

  logic         ck = 1'b0;
  logic         clr = 1'b1;
  logic [W-1:0] d = 16'h0000;
  logic [2:0]   dv = 3'b111;
  wire  [2:0]   rdy, so, sv, fs, done;

  int checks = 0;
  int failures = 0;

  always #5 ck = ~ck;

  word16_serializer #(.W(W), .MSB_FIRST(1'b1), .GAP(0)) u_msb (
    .CK(ck), .CLR(clr), .D(d), .DV(dv[0]), .RDY(rdy[0]),
    .SO(so[0]), .SV(sv[0]), .FS(fs[0]), .DONE(done[0]));

  word16_serializer #(.W(W), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
    .CK(ck), .CLR(clr), .D(d), .DV(dv[1]), .RDY(rdy[1]),
    .SO(so[1]), .SV(sv[1]), .FS(fs[1]), .DONE(done[1]));

  word16_serializer #(.W(W), .MSB_FIRST(1'b1), .GAP(3)) u_gap (
    .CK(ck), .CLR(clr), .D(d), .DV(dv[2]), .RDY(rdy[2]),
    .SO(so[2]), .SV(sv[2]), .FS(fs[2]), .DONE(done[2]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one or two words (second held on D with DV high) and checks every output cycle.
  // Each frame sample is packed as {SV, FS, DONE, SO-if-valid}.
  task automatic run_frames(input int inst, input int msb, input int gap,
                            input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input int nwords, input string tag);
    int period, f, p, bi;
    logic [W-1:0] w;
    logic [3:0] exp_v, obs_v;
    logic dbit;
    period = FL + gap;
    repeat (gap + 2) @(posedge ck);
    #1;
    d = w0;
    dv[inst] = 1'b1;
    check_val({tag, "_rdy_idle"}, 32'(rdy[inst]), 32'd1);
    @(posedge ck);
    #1;
    if (nwords > 1) d = w1;
    else            dv[inst] = 1'b0;
    for (int i = 0; i < nwords * period - gap; i++) begin
      @(posedge ck);
      #1;
      f = i / period;
      p = i % period;
      w = (f == 0) ? w0 : w1;
      bi = (msb != 0) ? (W - 1 - p) : p;
      if (p < FL) begin
        dbit = (p < W) ? w[bi] : ^w;
        exp_v = {1'b1, (p == 0), (p == FL - 1), dbit};
      end else begin
        exp_v = 4'b0000;
      end
      obs_v = {sv[inst], fs[inst], done[inst], exp_v[3] ? so[inst] : 1'b0};
      check_val($sformatf("%s_c%0d", tag, i), 32'(obs_v), 32'(exp_v));
      // RDY rises only in the cycle before the next word can be taken.
      if (i <= period - 2)
        check_val($sformatf("%s_rdy%0d", tag, i), 32'(rdy[inst]), 32'(i == period - 2));
      if (nwords > 1 && i == period - 1) dv[inst] = 1'b0;
    end
    @(posedge ck);
    #1;
    check_val({tag, "_tail_sv"}, 32'(sv[inst]), 32'd0);
  endtask

  initial begin
    // Reset held three cycles with DV high on every instance.
    repeat (3) @(posedge ck);
    #1;
    check_val("reset_outs", 32'({rdy, so, sv, fs, done}), 32'd0);
    clr = 1'b0;
    dv  = 3'b000;
    #1;
    check_val("rdy_after_release", 32'(rdy), 32'b111);
    repeat (2) @(posedge ck);
    #1;
    check_val("no_load_in_reset", 32'(sv), 32'd0);

    run_frames(0, 1, 0, 16'hA5C3, 16'h0000, 1, "msb_a5c3");
    run_frames(1, 0, 0, 16'h0001, 16'h0000, 1, "lsb_0001");
    run_frames(1, 0, 0, 16'hA5C3, 16'h0000, 1, "lsb_a5c3");
    run_frames(0, 1, 0, 16'hFFFF, 16'h0000, 2, "b2b");
    run_frames(2, 1, 3, 16'h1234, 16'h8001, 2, "gap3");
    run_frames(0, 1, 0, 16'h0007, 16'h0000, 1, "par_0007");

    // Abort at bit 8: SV must drop while CLR is high and no DONE appears.
    repeat (2) @(posedge ck);
    #1;
    d = 16'hFFFF;
    dv[0] = 1'b1;
    @(posedge ck);
    #1;
    dv[0] = 1'b0;
    repeat (8) @(posedge ck);
    #1;
    check_val("abort_pre_sv", 32'(sv[0]), 32'd1);
    clr = 1'b1;
    #1;
    check_val("abort_async", 32'({sv[0], fs[0], done[0], rdy[0]}), 32'd0);
    repeat (3) @(posedge ck);
    #1;
    check_val("abort_held", 32'({sv[0], fs[0], done[0], rdy[0]}), 32'd0);
    clr = 1'b0;
    run_frames(0, 1, 0, 16'h00F1, 16'h0000, 1, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
